// File: rtl/h_cmd_arb.sv
// h_cmd_arb: N_CH-channel round-robin command front-end for the h engine.
// Commands are granted round-robin onto the single h command port. The
// issuing channel is pushed into an in-order tag FIFO, and each h response
// is routed back to the channel at the head of that FIFO.
// Optional feature macro: H_CMD_ARB_STATS_EN adds cycle and per-channel
// issue counters (stat_cycle, stat_issued).

package h_pkg;
  typedef logic [1:0]  opcode_t;
  typedef logic [15:0] k_t;
  typedef logic [31:0] v_t;
  typedef logic [1:0]  status_t;

  typedef struct packed {
    opcode_t op;
    k_t      k;
    v_t      v;
  } cmd_t;
endpackage

module h_cmd_arb #(
  parameter int N_CH      = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              arst_n,
  input  logic [N_CH-1:0]                   cmd_vld,
  output logic [N_CH-1:0]                   cmd_rdy,
  input  h_pkg::opcode_t [N_CH-1:0]         cmd_opcode,
  input  h_pkg::k_t      [N_CH-1:0]         cmd_k,
  input  h_pkg::v_t      [N_CH-1:0]         cmd_v,
  output logic [N_CH-1:0]                   rsp_vld,
  output h_pkg::status_t                    rsp_status,
  output h_pkg::v_t                         rsp_v,
  output logic                              h_cmd_vld,
  output h_pkg::opcode_t                    h_cmd_opcode,
  output h_pkg::k_t                         h_cmd_k,
  output h_pkg::v_t                         h_cmd_v,
  input  logic                              h_rsp_vld,
  input  h_pkg::status_t                    h_rsp_status,
  input  h_pkg::v_t                         h_rsp_v,
  output logic [$clog2(TAG_DEPTH):0]        outstanding,
  output logic                              err_orphan
`ifdef H_CMD_ARB_STATS_EN
  ,
  output logic [31:0]                       stat_cycle,
  output logic [N_CH-1:0][31:0]             stat_issued
`endif
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // State
  logic [CH_W-1:0]                 rr_ptr_q,  rr_ptr_d;
  logic [PTR_W-1:0]                wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]                rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0]                cnt_q,     cnt_d;
  logic [TAG_DEPTH-1:0][CH_W-1:0]  tag_mem_q, tag_mem_d;
  logic                            orph_q,    orph_d;
  logic                            hvld_q,    hvld_d;
  h_pkg::cmd_t                     hcmd_q,    hcmd_d;
  logic [N_CH-1:0]                 rvld_q,    rvld_d;
  h_pkg::status_t                  rst_q,     rst_d;
  h_pkg::v_t                       rv_q,      rv_d;

  // Arbitration / FIFO control
  logic            gnt_found;
  logic [CH_W-1:0] gnt_idx;
  int              sel_c;
  logic            full, xfer, pop;
  logic [CH_W-1:0] head_tag;

  // Round-robin search upward from rr_ptr; full is judged on the registered count
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sel_c     = 0;
    for (int k = 0; k < N_CH; k++) begin
      sel_c = int'(rr_ptr_q) + k;
      if (sel_c >= N_CH) sel_c = sel_c - N_CH;
      if (!gnt_found && cmd_vld[sel_c]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(sel_c);
      end
    end
    full    = (cnt_q == CNT_W'(TAG_DEPTH));
    xfer    = gnt_found & ~full;
    cmd_rdy = '0;
    if (xfer) cmd_rdy[gnt_idx] = 1'b1;
  end

  // Next-state: pointer, FIFO, count, command and response registers
  always_comb begin
    pop      = h_rsp_vld & (cnt_q != '0);
    head_tag = tag_mem_q[rd_ptr_q];

    rr_ptr_d  = rr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_mem_d = tag_mem_q;
    cnt_d     = cnt_q;
    hcmd_d    = hcmd_q;
    hvld_d    = xfer;
    rvld_d    = '0;
    rst_d     = rst_q;
    rv_d      = rv_q;
    // an empty-FIFO response has no owner; flag it and drop it
    orph_d    = orph_q | (h_rsp_vld & (cnt_q == '0));

    if (xfer) begin
      rr_ptr_d            = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
      tag_mem_d[wr_ptr_q] = gnt_idx;
      wr_ptr_d            = wr_ptr_q + 1'b1;
      hcmd_d.op           = cmd_opcode[gnt_idx];
      hcmd_d.k            = cmd_k[gnt_idx];
      hcmd_d.v            = cmd_v[gnt_idx];
    end

    if (pop) begin
      rd_ptr_d         = rd_ptr_q + 1'b1;
      rvld_d[head_tag] = 1'b1;
      rst_d            = h_rsp_status;
      rv_d             = h_rsp_v;
    end

    case ({xfer, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_mem_q <= '0;
      cnt_q     <= '0;
      orph_q    <= 1'b0;
      hvld_q    <= 1'b0;
      hcmd_q    <= '0;
      rvld_q    <= '0;
      rst_q     <= '0;
      rv_q      <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tag_mem_q <= tag_mem_d;
      cnt_q     <= cnt_d;
      orph_q    <= orph_d;
      hvld_q    <= hvld_d;
      hcmd_q    <= hcmd_d;
      rvld_q    <= rvld_d;
      rst_q     <= rst_d;
      rv_q      <= rv_d;
    end
  end

  assign h_cmd_vld    = hvld_q;
  assign h_cmd_opcode = hcmd_q.op;
  assign h_cmd_k      = hcmd_q.k;
  assign h_cmd_v      = hcmd_q.v;
  assign rsp_vld      = rvld_q;
  assign rsp_status   = rst_q;
  assign rsp_v        = rv_q;
  assign outstanding  = cnt_q;
  assign err_orphan   = orph_q;

`ifdef H_CMD_ARB_STATS_EN
  logic [31:0]            stat_cycle_q,  stat_cycle_d;
  logic [N_CH-1:0][31:0]  stat_issued_q, stat_issued_d;

  // Free-running cycle count and per-channel transfer counts, wrapping
  always_comb begin
    stat_cycle_d  = stat_cycle_q + 32'd1;
    stat_issued_d = stat_issued_q;
    if (xfer) stat_issued_d[gnt_idx] = stat_issued_q[gnt_idx] + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stat_cycle_q  <= '0;
      stat_issued_q <= '0;
    end else begin
      stat_cycle_q  <= stat_cycle_d;
      stat_issued_q <= stat_issued_d;
    end
  end

  assign stat_cycle  = stat_cycle_q;
  assign stat_issued = stat_issued_q;
`endif

endmodule

// File: tb/tb_h_cmd_arb.sv
// Bench for h_cmd_arb: a table of directed vectors with constant expectations,
// hand sequences for round trip and mid-traffic reset, then random traffic
// against a queue-based reference model.
module tb_h_cmd_arb;
  localparam int N_CH      = 4;
  localparam int TAG_DEPTH = 8;

  logic                       clk = 1'b0;
  logic                       arst_n = 1'b0;
  logic [N_CH-1:0]            cmd_vld = '0;
  logic [N_CH-1:0]            cmd_rdy;
  h_pkg::opcode_t [N_CH-1:0]  cmd_opcode = '0;
  h_pkg::k_t      [N_CH-1:0]  cmd_k = '0;
  h_pkg::v_t      [N_CH-1:0]  cmd_v = '0;
  logic [N_CH-1:0]            rsp_vld;
  h_pkg::status_t             rsp_status;
  h_pkg::v_t                  rsp_v;
  logic                       h_cmd_vld;
  h_pkg::opcode_t             h_cmd_opcode;
  h_pkg::k_t                  h_cmd_k;
  h_pkg::v_t                  h_cmd_v;
  logic                       h_rsp_vld = 1'b0;
  h_pkg::status_t             h_rsp_status = '0;
  h_pkg::v_t                  h_rsp_v = '0;
  logic [$clog2(TAG_DEPTH):0] outstanding;
  logic                       err_orphan;
`ifdef H_CMD_ARB_STATS_EN
  logic [31:0]                stat_cycle;
  logic [N_CH-1:0][31:0]      stat_issued;
`endif

  h_cmd_arb #(.N_CH(N_CH), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .arst_n(arst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_opcode(cmd_opcode), .cmd_k(cmd_k), .cmd_v(cmd_v),
    .rsp_vld(rsp_vld), .rsp_status(rsp_status), .rsp_v(rsp_v),
    .h_cmd_vld(h_cmd_vld), .h_cmd_opcode(h_cmd_opcode),
    .h_cmd_k(h_cmd_k), .h_cmd_v(h_cmd_v),
    .h_rsp_vld(h_rsp_vld), .h_rsp_status(h_rsp_status), .h_rsp_v(h_rsp_v),
    .outstanding(outstanding), .err_orphan(err_orphan)
`ifdef H_CMD_ARB_STATS_EN
    , .stat_cycle(stat_cycle), .stat_issued(stat_issued)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int   mq[$];     // channels of commands issued and not yet answered
  int   m_rr = 0;
  bit   m_orph = 1'b0;
  logic [N_CH-1:0] smp_rdy;

  typedef struct {
    logic [N_CH-1:0] vld;
    logic            hrv;
    logic [N_CH-1:0] e_rdy;
    logic [N_CH-1:0] e_rsp;
    int              e_out;
    logic            e_orph;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr   = 0;
    m_orph = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".h_cmd_vld"}, 64'(h_cmd_vld), 64'd0);
    chk({tag, ".h_cmd"}, 64'({h_cmd_opcode, h_cmd_k, h_cmd_v}), 64'd0);
    chk({tag, ".rsp_vld"}, 64'(rsp_vld), 64'd0);
    chk({tag, ".rsp"}, 64'({rsp_status, rsp_v}), 64'd0);
    chk({tag, ".outstanding"}, 64'(outstanding), 64'd0);
    chk({tag, ".err_orphan"}, 64'(err_orphan), 64'd0);
  endtask

  // Called at a falling edge; applies one cycle and returns at the next falling edge.
  task automatic step(input logic [N_CH-1:0] vld, input logic hrv,
                      input h_pkg::status_t hst, input h_pkg::v_t hv);
    int g;
    int c;
    int t;
    logic [N_CH-1:0] e_rdy;
    logic [N_CH-1:0] e_rsp;
    logic [49:0]     e_cmd;
    h_pkg::status_t  e_st;
    h_pkg::v_t       e_v;
    cmd_vld = vld; h_rsp_vld = hrv; h_rsp_status = hst; h_rsp_v = hv;
    #1;
    g = -1;
    if (mq.size() < TAG_DEPTH)
      for (int k = 0; k < N_CH; k++) begin
        c = (m_rr + k) % N_CH;
        if (g < 0 && vld[c]) g = c;
      end
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    smp_rdy = cmd_rdy;
    chk("cmd_rdy", 64'(cmd_rdy), 64'(e_rdy));
    e_rsp = '0; e_st = '0; e_v = '0; e_cmd = '0;
    if (hrv) begin
      if (mq.size() > 0) begin
        t = mq.pop_front();
        e_rsp[t] = 1'b1; e_st = hst; e_v = hv;
      end else m_orph = 1'b1;
    end
    if (g >= 0) begin
      mq.push_back(g);
      m_rr  = (g + 1) % N_CH;
      e_cmd = {cmd_opcode[g], cmd_k[g], cmd_v[g]};
    end
    @(posedge clk);
    @(negedge clk);
    chk("h_cmd_vld", 64'(h_cmd_vld), 64'(g >= 0));
    if (g >= 0) chk("h_cmd_fields", 64'({h_cmd_opcode, h_cmd_k, h_cmd_v}), 64'(e_cmd));
    chk("rsp_vld", 64'(rsp_vld), 64'(e_rsp));
    if (e_rsp != '0) chk("rsp_data", 64'({rsp_status, rsp_v}), 64'({e_st, e_v}));
    chk("outstanding", 64'(outstanding), 64'(mq.size()));
    chk("err_orphan", 64'(err_orphan), 64'(m_orph));
  endtask

  task automatic do_reset();
    cmd_vld = '0; h_rsp_vld = 1'b0;
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    chk_all_zero("reset");
    arst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [N_CH-1:0] vld, input logic hrv,
                              input logic [N_CH-1:0] e_rdy, input logic [N_CH-1:0] e_rsp,
                              input int e_out, input logic e_orph);
    vec_t r;
    r.vld = vld; r.hrv = hrv; r.e_rdy = e_rdy; r.e_rsp = e_rsp;
    r.e_out = e_out; r.e_orph = e_orph;
    return r;
  endfunction

  initial begin
    // Fairness, full, full with same-cycle pop, drain, routing 3,0,3,1, orphan
    for (int i = 0; i < 8; i++) tbl.push_back(mk(4'hF, 1'b0, 4'(1 << (i % 4)), 4'h0, i + 1, 1'b0));
    tbl.push_back(mk(4'hF, 1'b0, 4'h0, 4'h0, 8, 1'b0));
    tbl.push_back(mk(4'h2, 1'b1, 4'h0, 4'h1, 7, 1'b0));
    tbl.push_back(mk(4'h2, 1'b0, 4'h2, 4'h0, 8, 1'b0));
    tbl.push_back(mk(4'h0, 1'b1, 4'h0, 4'h2, 7, 1'b0));
    tbl.push_back(mk(4'h0, 1'b1, 4'h0, 4'h4, 6, 1'b0));
    tbl.push_back(mk(4'h0, 1'b1, 4'h0, 4'h8, 5, 1'b0));
    tbl.push_back(mk(4'h0, 1'b1, 4'h0, 4'h1, 4, 1'b0));
    tbl.push_back(mk(4'h0, 1'b1, 4'h0, 4'h2, 3, 1'b0));
    tbl.push_back(mk(4'h0, 1'b1, 4'h0, 4'h4, 2, 1'b0));
    tbl.push_back(mk(4'h0, 1'b1, 4'h0, 4'h8, 1, 1'b0));
    tbl.push_back(mk(4'h0, 1'b1, 4'h0, 4'h2, 0, 1'b0));
    tbl.push_back(mk(4'h8, 1'b0, 4'h8, 4'h0, 1, 1'b0));
    tbl.push_back(mk(4'h1, 1'b0, 4'h1, 4'h0, 2, 1'b0));
    tbl.push_back(mk(4'h8, 1'b0, 4'h8, 4'h0, 3, 1'b0));
    tbl.push_back(mk(4'h2, 1'b0, 4'h2, 4'h0, 4, 1'b0));
    tbl.push_back(mk(4'h0, 1'b1, 4'h0, 4'h8, 3, 1'b0));
    tbl.push_back(mk(4'h0, 1'b1, 4'h0, 4'h1, 2, 1'b0));
    tbl.push_back(mk(4'h0, 1'b1, 4'h0, 4'h8, 1, 1'b0));
    tbl.push_back(mk(4'h0, 1'b1, 4'h0, 4'h2, 0, 1'b0));
    tbl.push_back(mk(4'h0, 1'b1, 4'h0, 4'h0, 0, 1'b1));

    @(negedge clk);
    do_reset();

    // Single channel round trip: ch2, k=5, h answers 3 cycles after issue
    for (int c = 0; c < N_CH; c++) begin
      cmd_opcode[c] = 2'(c); cmd_k[c] = 16'(16'h100 + c); cmd_v[c] = 32'(32'h1000 + c);
    end
    cmd_k[2] = 16'h5;
    step(4'b0100, 1'b0, 2'd0, 32'd0);
    chk("rt.h_cmd_k", 64'(h_cmd_k), 64'h5);
    chk("rt.out1", 64'(outstanding), 64'd1);
    repeat (3) step(4'b0000, 1'b0, 2'd0, 32'd0);
    step(4'b0000, 1'b1, 2'd0, 32'hA);
    chk("rt.rsp_vld", 64'(rsp_vld), 64'b0100);
    chk("rt.rsp_v", 64'(rsp_v), 64'hA);
    chk("rt.out0", 64'(outstanding), 64'd0);

    // Directed table from a fresh reset
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].hrv, 2'(i), 32'(32'hA0 + i));
      chk($sformatf("tbl%0d.rdy", i), 64'(smp_rdy), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d.rsp", i), 64'(rsp_vld), 64'(tbl[i].e_rsp));
      if (tbl[i].e_rsp != '0)
        chk($sformatf("tbl%0d.rsp_v", i), 64'(rsp_v), 64'(32'hA0 + i));
      chk($sformatf("tbl%0d.out", i), 64'(outstanding), 64'(tbl[i].e_out));
      chk($sformatf("tbl%0d.orph", i), 64'(err_orphan), 64'(tbl[i].e_orph));
    end

    // Mid-traffic reset with 3 tags outstanding and the orphan flag set
    step(4'b0001, 1'b0, 2'd0, 32'd0);
    step(4'b0010, 1'b0, 2'd0, 32'd0);
    step(4'b0100, 1'b0, 2'd0, 32'd0);
    chk("mid.out3", 64'(outstanding), 64'd3);
    cmd_vld = '0;
    #2 arst_n = 1'b0;
    #1;
    model_reset();
    chk_all_zero("mid_reset");
    @(negedge clk);
    arst_n = 1'b1;
    step(4'b1000, 1'b0, 2'd0, 32'd0);
    step(4'b0000, 1'b1, 2'd1, 32'h77);
    chk("post_reset.rsp", 64'(rsp_vld), 64'b1000);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        cmd_opcode[c] = 2'($urandom); cmd_k[c] = 16'($urandom); cmd_v[c] = $urandom;
      end
      step(4'($urandom), ($urandom_range(0, 2) == 0), 2'($urandom), $urandom);
    end

`ifdef H_CMD_ARB_STATS_EN
    // 5 transfers on ch0 in 20 cycles after reset release
    cmd_vld = '0; h_rsp_vld = 1'b0;
    arst_n = 1'b0;
    @(negedge clk);
    model_reset();
    arst_n = 1'b1;
    for (int n = 0; n < 20; n++)
      step((n % 4 == 0) ? 4'b0001 : 4'b0000, 1'b0, 2'd0, 32'd0);
    chk("stat_cycle", 64'(stat_cycle), 64'd20);
    chk("stat_issued0", 64'(stat_issued[0]), 64'd5);
    chk("stat_issued_rest", 64'({stat_issued[3], stat_issued[2], stat_issued[1]}), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/h_cmd_arb.md
# h_cmd_arb

Parametrised multi-channel command front-end for the `h` hash-table engine. It accepts commands from `N_CH` independent requesters, arbitrates them round-robin onto the single `h` command port, and records the issuing channel of every command in an in-order tag FIFO. Each `h` response is then routed back to the channel that issued it. It sits between the requesters (or the testbench drivers) and `u_h`, replacing the single-channel direct connection.

## Interface
Parameters:
- `N_CH`, 4, number of requester channels (2..16)
- `TAG_DEPTH`, 8, maximum outstanding commands; power of two, 2..64

Ports:
- `clk` in 1: sole clock, rising edge
- `arst_n` in 1: asynchronous active-low reset
- `cmd_vld` in N_CH: per-channel command valid
- `cmd_rdy` out N_CH: per-channel accept (grant)
- `cmd_opcode` in N_CH×`h_pkg::opcode_t`: per-channel opcode
- `cmd_k` in N_CH×`h_pkg::k_t`: per-channel key
- `cmd_v` in N_CH×`h_pkg::v_t`: per-channel value
- `rsp_vld` out N_CH: per-channel response valid, one-hot or zero
- `rsp_status` out `h_pkg::status_t`: response status, shared by all channels
- `rsp_v` out `h_pkg::v_t`: response value, shared by all channels
- `h_cmd_vld` / `h_cmd_opcode` / `h_cmd_k` / `h_cmd_v` out: command to `h`
- `h_rsp_vld` / `h_rsp_status` / `h_rsp_v` in: response from `h`
- `outstanding` out $clog2(TAG_DEPTH)+1: commands issued but not yet responded
- `err_orphan` out 1: sticky; set when a response arrives with no tag outstanding

## Operation
- **Grant.**
  - `cmd_rdy[i]` is combinational. It is 1 only for the first channel with `cmd_vld` set, searching upward from `rr_ptr` with wrap-around.
  - No grant is given while `outstanding == TAG_DEPTH`.
  - At most one grant per cycle.
  - A transfer occurs on `cmd_vld[i] & cmd_rdy[i]`.
- **Pointer.** On a transfer on channel g, `rr_ptr` ← (g+1) mod N_CH. Otherwise `rr_ptr` holds.
- **Issue.**
  - On a transfer, the selected opcode/k/v are registered onto `h_cmd_*` and `h_cmd_vld` is set for exactly one cycle.
  - In the same cycle, g is pushed into the tag FIFO.
- **Return.**
  - On `h_rsp_vld` with the FIFO non-empty, the head tag t is popped.
  - Next cycle: `rsp_vld[t]`=1, and `rsp_status`/`rsp_v` carry the registered `h_rsp_status`/`h_rsp_v`.
- **Ordering.** Responses from `h` are in issue order, so FIFO order is authoritative.
- **Outstanding count.**
  - Push only: +1. Pop only: −1. Push and pop in the same cycle: unchanged.
- **Full FIFO.** All `cmd_rdy` are 0. A pop in the same cycle does not enable a grant until the next cycle (full is evaluated on the registered count).
- **Orphan response.**
  - `h_rsp_vld` with the FIFO empty sets `err_orphan`.
  - No `rsp_vld` is generated and the count stays 0.
  - `err_orphan` clears only on reset.
- **Reset values.** On `arst_n` low, immediately and mid-operation:
  - FIFO pointers cleared, `rr_ptr`=0, `outstanding`=0, `err_orphan`=0.
  - `h_cmd_vld`=0, `h_cmd_opcode`/`h_cmd_k`/`h_cmd_v`=0.
  - `rsp_vld`=0, `rsp_status`=0, `rsp_v`=0.
  - In-flight tags are discarded; `h` shares the same reset.

## Timing
- Command path: transfer in cycle n → `h_cmd_vld` high in cycle n+1.
- Response path: `h_rsp_vld` in cycle m → `rsp_vld[t]` high in cycle m+1.
- Throughput: one command and one response per cycle, sustained.
- `cmd_rdy` depends combinationally on `cmd_vld`. Requesters must not make `cmd_vld` depend on `cmd_rdy`.
- `outstanding` and `err_orphan` are registered and update the cycle after the causing event.

## Configuration
- `H_CMD_ARB_STATS_EN`
  - **Defined:** adds output ports `stat_cycle` [31:0] and `stat_issued` [N_CH×32].
    - `stat_cycle` increments every clock after reset.
    - `stat_issued[i]` increments on each transfer on channel i.
    - All counters reset to 0 and wrap modulo 2^32.
  - **Undefined:** these ports and counters do not exist. Functional behaviour is otherwise identical.

## Test plan
- **Single channel, round trip.**
  - Stimulus: channel 2 sends one command with k=0x5; `h` responds 3 cycles after issue with status OK, v=0xA.
  - Required: `h_cmd_vld` one cycle after the transfer; `rsp_vld`=4'b0100 with v=0xA one cycle after `h_rsp_vld`; `outstanding` goes 0→1→0.
- **Fairness.**
  - Stimulus: all four channels hold `cmd_vld` for 8 cycles with `h` never responding, `TAG_DEPTH`=8.
  - Required: grant order 0,1,2,3,0,1,2,3; then all `cmd_rdy`=0 with `outstanding`=8.
- **Full with same-cycle pop.**
  - Stimulus: FIFO full; `h_rsp_vld` pulses once while channel 1 is valid.
  - Required: no grant that cycle; channel 1 granted the next cycle; `outstanding` goes 8→7→8.
- **Response routing.**
  - Stimulus: issue channels 3,0,3,1 back to back; `h` responds in order.
  - Required: `rsp_vld` sequence 1000, 0001, 1000, 0010.
- **Orphan and reset.**
  - Stimulus: `h_rsp_vld` with the FIFO empty, then `arst_n` pulsed low mid-traffic with 3 tags outstanding.
  - Required: `err_orphan`=1 and no `rsp_vld`; after reset `outstanding`=0, `err_orphan`=0, all outputs 0.
- **Stats (macro defined).**
  - Stimulus: 5 transfers on channel 0 over 20 cycles.
  - Required: `stat_issued[0]`=5, others 0; `stat_cycle`=20.
